// File: rtl/fibonacci_index_finder.sv
// Finds the smallest index n with F(n) >= value (F(0)=F(1)=1), one series term per cycle.
// Flags exact matches and values beyond the largest term that fits DATA_WIDTH.
module fibonacci_index_finder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  out_is_fib,
    output logic                  out_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [IDX_WIDTH-1:0]  r_n;
    logic [IDX_WIDTH-1:0]  r_index;
    logic                  r_is_fib;
    logic                  r_overflow;

    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_accept;
    logic                  w_hit;
    logic                  w_ovf;
    logic                  w_step;
    logic                  w_release;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Rule order matters: a hit on the current term wins over overflow detection,
    // so a truncated b is only ever seen as a after the hit check.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_hit        = 1'b0;
        w_ovf        = 1'b0;
        w_step       = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (r_a >= r_value) begin
                    w_hit        = 1'b1;
                    w_state_next = ST_DONE;
                end else if ((r_b < r_value) && w_sum[DATA_WIDTH]) begin
                    w_ovf        = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_n        <= '0;
            r_index    <= '0;
            r_is_fib   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_value <= in_value;
                r_a     <= ONE;
                r_b     <= ONE;
                r_n     <= '0;
            end
            if (w_hit) begin
                r_index    <= r_n;
                r_is_fib   <= (r_a == r_value);
                r_overflow <= 1'b0;
            end
            if (w_ovf) begin
                r_index    <= r_n + 1'b1;
                r_is_fib   <= 1'b0;
                r_overflow <= 1'b1;
            end
            if (w_step) begin
                r_a <= r_b;
                r_b <= w_sum[DATA_WIDTH-1:0];
                r_n <= r_n + 1'b1;
            end
        end
    end

    assign out_index    = r_index;
    assign out_is_fib   = r_is_fib;
    assign out_overflow = r_overflow;

endmodule
